// File: rtl/vector_threshold_comparator.sv
// Streams one signed vector, flags each element whose magnitude is strictly below a
// latched threshold, and publishes the packed flags together with a one-cycle strobe.
module vector_threshold_comparator #(
   parameter int size_of_data = 6,
   parameter int DATA_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_W-1:0]       threshold,
   input  logic                    clear,
   input  logic                    elem_valid,
   input  logic [DATA_W-1:0]       elem_data,
   output logic                    elem_ready,
   output logic                    busy,
   output logic                    flags_valid,
   output logic [size_of_data-1:0] flag_vectors_comparator,
   output logic [1:0]              dbg_state
);

   localparam int IDX_W = (size_of_data > 1) ? $clog2(size_of_data) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size_of_data - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PUBLISH = 2'd2
   } state_t;

   state_t                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic [size_of_data-1:0] shadow_q;
   logic [size_of_data-1:0] flags_q;
   logic [DATA_W-1:0]       thr_q;
   logic                    flags_valid_q;

   // Handshake: an element moves when elem_valid and elem_ready are both high at a
   // rising edge; elem_ready depends only on state, so a source may stall indefinitely.
   logic              xfer;
   logic [DATA_W:0]   elem_ext;
   logic [DATA_W:0]   elem_abs;
   logic              below_thr;

   assign elem_ready = (state_q == S_COLLECT);
   assign busy       = (state_q != S_IDLE);
   assign xfer       = elem_valid & elem_ready;

   // One extra bit keeps the magnitude of the most negative element representable.
   assign elem_ext  = {elem_data[DATA_W-1], elem_data};
   assign elem_abs  = elem_data[DATA_W-1] ? (-elem_ext) : elem_ext;
   assign below_thr = (elem_abs < {1'b0, thr_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         shadow_q      <= '0;
         flags_q       <= '0;
         thr_q         <= '0;
         flags_valid_q <= 1'b0;
      end else begin
         flags_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!clear && start) begin
                  thr_q    <= threshold;
                  idx_q    <= '0;
                  shadow_q <= '0;
                  state_q  <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (clear) begin
                  idx_q    <= '0;
                  shadow_q <= '0;
                  state_q  <= S_IDLE;
               end else if (xfer) begin
                  shadow_q[idx_q] <= below_thr;
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     state_q <= S_PUBLISH;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            S_PUBLISH: begin
               flags_q       <= shadow_q;
               flags_valid_q <= 1'b1;
               state_q       <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign flags_valid             = flags_valid_q;
   assign flag_vectors_comparator = flags_q;
   assign dbg_state               = state_q;

endmodule

// File: tb/tb_vector_threshold_comparator.sv
// Bench for vector_threshold_comparator: a 6-element and a 4-element instance driven with
// directed and random vectors, checked against a magnitude-compare model via a scoreboard.
module tb_vector_threshold_comparator;

   localparam int N  = 6;
   localparam int N4 = 4;
   localparam int W  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic         start = 0, clear = 0, elem_valid = 0;
   logic [W-1:0] threshold = '0, elem_data = '0;
   logic         elem_ready, busy, flags_valid;
   logic [N-1:0] flags;
   logic [1:0]   dbg_state;

   logic          start4 = 0, clear4 = 0, valid4 = 0;
   logic [W-1:0]  thr4 = '0, data4 = '0;
   logic          rdy4, busy4, fv4;
   logic [N4-1:0] flags4;
   logic [1:0]    dbg_state4;

   vector_threshold_comparator #(.size_of_data(N), .DATA_W(W)) u_dut (
      .clk(clk), .rst(rst), .start(start), .threshold(threshold), .clear(clear),
      .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready), .busy(busy),
      .flags_valid(flags_valid), .flag_vectors_comparator(flags), .dbg_state(dbg_state));

   vector_threshold_comparator #(.size_of_data(N4), .DATA_W(W)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .threshold(thr4), .clear(clear4),
      .elem_valid(valid4), .elem_data(data4), .elem_ready(rdy4), .busy(busy4),
      .flags_valid(fv4), .flag_vectors_comparator(flags4), .dbg_state(dbg_state4));

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [N-1:0]  exp_q[$];
   int            due_q[$];
   logic [N4-1:0] exp4_q[$];
   int            due4_q[$];
   logic [W-1:0]  vec[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: flag i is set when the true magnitude of element i is below the threshold.
   function automatic logic [7:0] model(input logic [W-1:0] e[$], input logic [W-1:0] thr);
      logic [7:0] r;
      int v;
      r = '0;
      foreach (e[i]) begin
         v = int'($signed(e[i]));
         if (v < 0) v = -v;
         r[i] = (v < int'(thr));
      end
      return r;
   endfunction

   // ---------------- monitors ----------------
   logic [N-1:0]  held6 = '0, e6;
   logic [N4-1:0] held4 = '0, e4;
   logic          prev6 = 0, prev4 = 0;
   int            d6, d4;

   always @(negedge clk) begin
      if (rst) begin
         held6 = '0;
         prev6 = 0;
      end else begin
         if (flags_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe6", {31'd0, prev6}, 32'd2);
            end else begin
               e6 = exp_q.pop_front();
               d6 = due_q.pop_front();
               check("flags6", flags, e6);
               check("latency6", cyc, d6);
               check("strobe_width6", prev6, 0);
               held6 = e6;
            end
         end else begin
            check("flags6_hold", flags, held6);
         end
         prev6 = flags_valid;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         held4 = '0;
         prev4 = 0;
      end else begin
         if (fv4) begin
            if (exp4_q.size() == 0) begin
               check("unexpected_strobe4", {31'd0, prev4}, 32'd2);
            end else begin
               e4 = exp4_q.pop_front();
               d4 = due4_q.pop_front();
               check("flags4", flags4, e4);
               check("latency4", cyc, d4);
               check("strobe_width4", prev4, 0);
               held4 = e4;
            end
         end else begin
            check("flags4_hold", flags4, held4);
         end
         prev4 = fv4;
      end
   end

   // ---------------- drivers ----------------
   task automatic drv_start(input bit sel, input logic s, input logic [W-1:0] t);
      if (sel) begin start4 = s; thr4 = t; end
      else begin start = s; threshold = t; end
   endtask

   task automatic drv_elem(input bit sel, input logic v, input logic [W-1:0] d);
      if (sel) begin valid4 = v; data4 = d; end
      else begin elem_valid = v; elem_data = d; end
   endtask

   task automatic wait_done();
      for (int k = 0; k < 10 && (exp_q.size() + exp4_q.size()) != 0; k++) begin
         @(negedge clk);
         #1;
      end
      check("strobe_seen", exp_q.size() + exp4_q.size(), 0);
      exp_q.delete(); due_q.delete(); exp4_q.delete(); due4_q.delete();
   endtask

   // Sends the contents of vec; poke >= 0 raises start (other threshold) with that element.
   task automatic send_vec(input bit sel, input logic [W-1:0] thr, input int gap,
                           input bit rnd_gap, input int poke);
      logic [7:0] m;
      int n, g;
      n = vec.size();
      m = model(vec, thr);
      @(posedge clk); #1; drv_start(sel, 1'b1, thr);
      @(posedge clk); #1; drv_start(sel, 1'b0, W'($urandom));
      for (int i = 0; i < n; i++) begin
         g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
         for (int k = 0; k < g; k++) begin
            drv_elem(sel, 1'b0, W'($urandom));
            @(negedge clk);
            check("ready_gap", sel ? rdy4 : elem_ready, 1);
            @(posedge clk); #1;
         end
         drv_elem(sel, 1'b1, vec[i]);
         if (i == poke) drv_start(sel, 1'b1, thr ^ 16'h00FF);
         @(negedge clk);
         check("ready_xfer", sel ? rdy4 : elem_ready, 1);
         check("busy_xfer", sel ? busy4 : busy, 1);
         if (i == n - 1) begin
            if (sel) begin exp4_q.push_back(m[N4-1:0]); due4_q.push_back(cyc + 2); end
            else begin exp_q.push_back(m[N-1:0]); due_q.push_back(cyc + 2); end
         end
         @(posedge clk); #1;
         drv_elem(sel, 1'b0, W'($urandom));
         drv_start(sel, 1'b0, W'($urandom));
      end
      wait_done();
   endtask

   function automatic logic [W-1:0] rnd_elem(input logic [W-1:0] thr);
      case ($urandom_range(4, 0))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return thr;
         3:       return -thr;
         default: return W'($urandom_range(600, 0) - 300);
      endcase
   endfunction

   task automatic fill_vec(input int n, input logic [W-1:0] thr);
      vec.delete();
      for (int i = 0; i < n; i++) vec.push_back(rnd_elem(thr));
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] rthr;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", flags, 0);
      check("rst_strobe", flags_valid, 0);
      check("rst_ready", elem_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, 0);
      check("rst_flags4", flags4, 0);
      @(posedge clk); #3; rst = 0;

      // Directed vector, back-to-back then one element every third cycle.
      vec = {16'd5, 16'hFFFB, 16'd99, 16'd100, 16'hFF9B, 16'd0};
      send_vec(0, 16'd100, 0, 0, -1);
      send_vec(0, 16'd100, 2, 0, -1);

      // Magnitude extremes and a zero threshold.
      vec = {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
      send_vec(0, 16'd32767, 0, 0, -1);
      fill_vec(N, 16'd0);
      send_vec(0, 16'd0, 1, 1, -1);

      // Re-establish a known non-zero published vector before the abort case.
      vec = {16'd5, 16'hFFFB, 16'd99, 16'd100, 16'hFF9B, 16'd0};
      send_vec(0, 16'd100, 0, 0, -1);

      // Abort after three elements; the dropped fourth arrives with clear.
      @(posedge clk); #1; start = 1; threshold = 16'd10;
      @(posedge clk); #1; start = 0; threshold = 16'd500;
      for (int i = 0; i < 3; i++) begin
         elem_valid = 1; elem_data = W'($urandom);
         @(posedge clk); #1;
      end
      clear = 1;
      @(posedge clk); #1; clear = 0; elem_valid = 0;
      @(negedge clk);
      check("clear_state", dbg_state, 0);
      check("clear_busy", busy, 0);
      check("clear_ready", elem_ready, 0);
      repeat (4) @(negedge clk);

      // Start and clear together in idle, then stray elements while idle.
      @(posedge clk); #1; start = 1; clear = 1; threshold = 16'd7;
      @(posedge clk); #1; start = 0; clear = 0;
      @(negedge clk);
      check("start_clear_idle", dbg_state, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; elem_valid = 1; elem_data = W'($urandom);
         @(negedge clk);
         check("valid_in_idle", dbg_state, 0);
      end
      @(posedge clk); #1; elem_valid = 0;

      // Restart completes from element 0 with threshold 10; a start mid-vector is ignored.
      fill_vec(N, 16'd10);
      send_vec(0, 16'd10, 1, 1, 2);

      // Asynchronous reset between edges in the middle of a vector.
      vec = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
      send_vec(0, 16'd100, 0, 0, -1);
      @(posedge clk); #1; start = 1; threshold = 16'd100;
      @(posedge clk); #1; start = 0; elem_valid = 1; elem_data = 16'd3;
      @(posedge clk); #1;
      @(posedge clk); #2; rst = 1;
      #1;
      check("arst_flags", flags, 0);
      check("arst_strobe", flags_valid, 0);
      check("arst_ready", elem_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_state", dbg_state, 0);
      elem_valid = 0;
      @(posedge clk); #3; rst = 0;

      // Random vectors on the 6-element instance.
      for (int t = 0; t < 16; t++) begin
         rthr = ($urandom_range(2, 0) == 0) ? W'($urandom) : W'($urandom_range(300, 0));
         fill_vec(N, rthr);
         send_vec(0, rthr, 3, 1, ($urandom_range(3, 0) == 0) ? int'($urandom_range(N - 1, 0)) : -1);
      end

      // 4-element instance: directed vector, then hold the value, then random.
      vec = {16'd7, 16'd8, 16'hFFF9, 16'hFFF7};
      send_vec(1, 16'd8, 0, 0, -1);
      repeat (5) @(negedge clk);
      for (int t = 0; t < 6; t++) begin
         rthr = W'($urandom_range(300, 0));
         fill_vec(N4, rthr);
         send_vec(1, rthr, 2, 1, -1);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
